// File: rtl/auth_msg_serializer.sv
// Framed serial transmitter for authentication messages: preamble, LSB-first payload,
// MSB-first CRC-8 (poly 0x07) and a single end-of-packet bit, each bit held CLK_DIV cycles.
module auth_msg_serializer #(
   parameter int MSG_LEN      = 64,
   parameter int PREAMBLE_LEN = 8,
   parameter int CLK_DIV      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MSG_LEN-1:0] auth_msg_out,
   input  logic               auth_msg_ready,
   output logic               msg_ack,
   output logic               busy,
   output logic               tx_en,
   output logic               tx_data,
   output logic               tx_done
);

   localparam int MAX_LEN = (PREAMBLE_LEN > MSG_LEN) ? PREAMBLE_LEN : MSG_LEN;
   localparam int BIT_W   = $clog2(MAX_LEN + 1);
   localparam int DIV_W   = $clog2(CLK_DIV) + 1;

   localparam logic [BIT_W-1:0] LAST_PRE = BIT_W'(PREAMBLE_LEN - 1);
   localparam logic [BIT_W-1:0] LAST_MSG = BIT_W'(MSG_LEN - 1);
   localparam logic [BIT_W-1:0] LAST_CRC = BIT_W'(7);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_DATA     = 3'd2;
   localparam logic [2:0] S_CRC      = 3'd3;
   localparam logic [2:0] S_EOP      = 3'd4;

   localparam logic [7:0] CRC_POLY = 8'h07;

   logic [2:0]         state_q,   state_d;
   logic [BIT_W-1:0]   bit_q,     bit_d;
   logic [DIV_W-1:0]   div_q,     div_d;
   logic [MSG_LEN-1:0] shift_q,   shift_d;
   logic [7:0]         crc_q,     crc_d;
   logic               tx_data_q, tx_data_d;
   logic               tx_en_q,   tx_en_d;
   logic               busy_q,    busy_d;
   logic               msg_ack_q, msg_ack_d;
   logic               tx_done_q, tx_done_d;
   logic               bit_end;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
   endfunction

   // state_q names the phase of the bit currently on tx_data; every change of tx_data
   // happens on the edge that ends the previous bit time, so the outputs are glitch-free flops.
   always_comb begin
      // NOTE: every _d starts from its _q (pulses from 0) so no branch leaves one unassigned and infers a latch.
      state_d   = state_q;
      bit_d     = bit_q;
      div_d     = div_q;
      shift_d   = shift_q;
      crc_d     = crc_q;
      tx_data_d = tx_data_q;
      tx_en_d   = tx_en_q;
      busy_d    = busy_q;
      msg_ack_d = 1'b0;
      tx_done_d = 1'b0;
      bit_end   = (div_q == LAST_DIV);

      if (state_q == S_IDLE) begin
         if (auth_msg_ready) begin
            state_d   = S_PREAMBLE;
            bit_d     = '0;
            div_d     = '0;
            shift_d   = auth_msg_out;
            crc_d     = 8'h00;
            tx_data_d = 1'b1;
            tx_en_d   = 1'b1;
            busy_d    = 1'b1;
            msg_ack_d = 1'b1;
         end
      end else if (!bit_end) begin
         div_d = div_q + 1'b1;
      end else begin
         div_d = '0;
         bit_d = bit_q + 1'b1;
         case (state_q)
            S_PREAMBLE: begin
               if (bit_q == LAST_PRE) begin
                  state_d   = S_DATA;
                  bit_d     = '0;
                  tx_data_d = shift_q[0];
                  shift_d   = {1'b0, shift_q[MSG_LEN-1:1]};
                  crc_d     = crc8_step(crc_q, shift_q[0]);
               end else begin
                  // Next preamble index is bit_q+1, whose inverted LSB equals bit_q[0].
                  tx_data_d = bit_q[0];
               end
            end
            S_DATA: begin
               if (bit_q == LAST_MSG) begin
                  state_d   = S_CRC;
                  bit_d     = '0;
                  tx_data_d = crc_q[7];
               end else begin
                  tx_data_d = shift_q[0];
                  shift_d   = {1'b0, shift_q[MSG_LEN-1:1]};
                  crc_d     = crc8_step(crc_q, shift_q[0]);
               end
            end
            S_CRC: begin
               if (bit_q == LAST_CRC) begin
                  state_d   = S_EOP;
                  bit_d     = '0;
                  tx_data_d = 1'b0;
               end else begin
                  tx_data_d = crc_q[3'd6 - bit_q[2:0]];
               end
            end
            S_EOP: begin
               state_d   = S_IDLE;
               bit_d     = '0;
               tx_data_d = 1'b0;
               tx_en_d   = 1'b0;
               busy_d    = 1'b0;
               tx_done_d = 1'b1;
            end
            default: begin
               state_d   = S_IDLE;
               bit_d     = '0;
               tx_data_d = 1'b0;
               tx_en_d   = 1'b0;
               busy_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         bit_q     <= '0;
         div_q     <= '0;
         shift_q   <= '0;
         crc_q     <= 8'h00;
         tx_data_q <= 1'b0;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         msg_ack_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         shift_q   <= shift_d;
         crc_q     <= crc_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         busy_q    <= busy_d;
         msg_ack_q <= msg_ack_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign msg_ack = msg_ack_q;
   assign busy    = busy_q;
   assign tx_en   = tx_en_q;
   assign tx_data = tx_data_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_auth_msg_serializer.sv
// Directed bench for auth_msg_serializer: table of frames with hand-computed CRCs plus
// hand-written held-ready, mid-frame reset and CLK_DIV=1 sequences.
module tb_auth_msg_serializer;

   localparam int MSG_LEN = 8;
   localparam int PRE_LEN = 4;
   localparam int NBITS   = PRE_LEN + MSG_LEN + 9;

   typedef struct {
      logic [7:0] msg;
      logic [7:0] mid_msg;
      logic [7:0] crc;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] auth_msg;
   logic       rdy_a, rdy_b;
   logic       ack_a, busy_a, en_a, data_a, done_a;
   logic       ack_b, busy_b, en_b, data_b, done_b;
   logic       sel;
   logic       s_ack, s_busy, s_en, s_data, s_done;
   int         errors = 0;
   int         checks = 0;
   vec_t       vecs[5];

   always #5 clk = ~clk;

   auth_msg_serializer #(.MSG_LEN(MSG_LEN), .PREAMBLE_LEN(PRE_LEN), .CLK_DIV(2)) dut_a (
      .clk(clk), .reset(reset), .auth_msg_out(auth_msg), .auth_msg_ready(rdy_a),
      .msg_ack(ack_a), .busy(busy_a), .tx_en(en_a), .tx_data(data_a), .tx_done(done_a)
   );

   auth_msg_serializer #(.MSG_LEN(MSG_LEN), .PREAMBLE_LEN(PRE_LEN), .CLK_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .auth_msg_out(auth_msg), .auth_msg_ready(rdy_b),
      .msg_ack(ack_b), .busy(busy_b), .tx_en(en_b), .tx_data(data_b), .tx_done(done_b)
   );

   assign s_ack  = sel ? ack_b  : ack_a;
   assign s_busy = sel ? busy_b : busy_a;
   assign s_en   = sel ? en_b   : en_a;
   assign s_data = sel ? data_b : data_a;
   assign s_done = sel ? done_b : done_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_ready(input logic v);
      rdy_a = v & ~sel;
      rdy_b = v & sel;
   endtask

   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] m, input logic [7:0] c);
      logic [NBITS-1:0] f;
      f[0] = 1'b1; f[1] = 1'b0; f[2] = 1'b1; f[3] = 1'b0;
      for (int i = 0; i < 8; i++) f[PRE_LEN + i] = m[i];
      for (int j = 0; j < 8; j++) f[PRE_LEN + MSG_LEN + j] = c[7 - j];
      f[NBITS-1] = 1'b0;
      return f;
   endfunction

   // Called at a negedge; returns at the negedge following the capture edge.
   task automatic start_frame(input logic [7:0] msg, input bit hold);
      auth_msg = msg;
      set_ready(1'b1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) set_ready(1'b0);
   endtask

   // Samples one cycle per negedge from the first frame cycle until tx_done, then one more.
   task automatic capture_frame(input logic [7:0] msg, input logic [7:0] mid_msg,
                                input logic [7:0] crc, input int div, input string tag);
      logic [NBITS-1:0] exp;
      int en_cnt, bit_err, busy_err, ack_cnt, done_pos;
      logic ack_first;
      exp = frame_bits(msg, crc);
      en_cnt = 0; bit_err = 0; busy_err = 0; ack_cnt = 0; done_pos = -1; ack_first = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c == 12) auth_msg = mid_msg;
         if (c == 0) ack_first = s_ack;
         if (s_ack === 1'b1) ack_cnt++;
         if (s_busy !== s_en) busy_err++;
         if (s_en === 1'b1) begin
            en_cnt++;
            if ((c / div) < NBITS && s_data !== exp[c / div]) bit_err++;
         end
         if (s_done === 1'b1) begin
            done_pos = c;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("%s tx_en cycles", tag), en_cnt, NBITS * div);
      check($sformatf("%s bit errors", tag), bit_err, 0);
      check($sformatf("%s busy vs tx_en", tag), busy_err, 0);
      check($sformatf("%s msg_ack count", tag), ack_cnt, 1);
      check($sformatf("%s msg_ack first cycle", tag), ack_first, 1);
      check($sformatf("%s tx_done position", tag), done_pos, NBITS * div);
      @(negedge clk);
      check($sformatf("%s tx_done one cycle", tag), s_done, 0);
   endtask

   initial begin
      int done_seen;
      reset = 1'b1;
      auth_msg = 8'h00;
      sel = 1'b0;
      set_ready(1'b0);
      vecs[0] = '{8'h01, 8'h01, 8'h89};
      vecs[1] = '{8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'h01, 8'hFF, 8'h89};
      vecs[3] = '{8'h80, 8'h80, 8'h07};
      vecs[4] = '{8'hFF, 8'hFF, 8'hF3};

      repeat (2) @(negedge clk);
      check("reset msg_ack", ack_a, 0);
      check("reset busy", busy_a, 0);
      check("reset tx_en", en_a, 0);
      check("reset tx_data", data_a, 0);
      check("reset tx_done", done_a, 0);
      check("reset tx_en div1", en_b, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         start_frame(vecs[v].msg, 1'b0);
         capture_frame(vecs[v].msg, vecs[v].mid_msg, vecs[v].crc, 2, $sformatf("vec%0d", v));
         repeat (3) @(negedge clk);
      end

      // Ready held across a whole frame: re-captured only in the tx_done cycle.
      start_frame(8'h01, 1'b1);
      capture_frame(8'h01, 8'h01, 8'h89, 2, "held first");
      check("held second tx_en", s_en, 1);
      check("held second msg_ack", s_ack, 1);
      set_ready(1'b0);
      capture_frame(8'h01, 8'h01, 8'h89, 2, "held second");
      repeat (3) @(negedge clk);

      // Reset during DATA: outputs drop without a clock edge, and no tx_done follows.
      start_frame(8'h01, 1'b0);
      repeat (8) @(negedge clk);
      check("pre-reset tx_data", s_data, 1);
      #1 reset = 1'b1;
      #1;
      check("async reset tx_en", s_en, 0);
      check("async reset tx_data", s_data, 0);
      check("async reset busy", s_busy, 0);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (s_done === 1'b1 || s_en === 1'b1) done_seen++;
      end
      check("no tx_done after reset", done_seen, 0);
      start_frame(8'h01, 1'b0);
      capture_frame(8'h01, 8'h01, 8'h89, 2, "after reset");
      repeat (3) @(negedge clk);

      // Same 0x01 frame on the CLK_DIV=1 instance.
      sel = 1'b1;
      set_ready(1'b0);
      @(negedge clk);
      start_frame(8'h01, 1'b0);
      capture_frame(8'h01, 8'h01, 8'h89, 1, "div1");
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/auth_msg_serializer.md
# auth_msg_serializer

Downstream transmit stage for the authentication driver. Captures the parallel authentication message on `auth_msg_ready`, then emits a framed serial bit stream: preamble, message bits, CRC-8 and end-of-packet. The stream goes toward the Type-C line interface (CC/TX lane driver). While a frame is in flight the block is busy, and it acknowledges each capture back to the driver.

## Interface
- `MSG_LEN`, 64: message width in bits; must be ≥ 8.
- `PREAMBLE_LEN`, 8: preamble length in bit times; must be ≥ 2.
- `CLK_DIV`, 4: clock cycles per bit time; must be ≥ 1.

- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `auth_msg_out` in `MSG_LEN`: parallel message from the authentication driver.
- `auth_msg_ready` in 1: message valid; sampled only in IDLE.
- `msg_ack` out 1: one-cycle pulse confirming capture.
- `busy` out 1: high from capture until the frame ends.
- `tx_en` out 1: line driver enable; high for the whole frame.
- `tx_data` out 1: serial bit, meaningful only when `tx_en`=1.
- `tx_done` out 1: one-cycle pulse at frame end.

## Operation
- **States:** IDLE → PREAMBLE → DATA → CRC → EOP → IDLE.
- **IDLE:**
  - If `auth_msg_ready`=1 on a rising edge, latch `auth_msg_out` into the shift register and clear CRC to 0x00.
  - Go to PREAMBLE with `tx_en`=1 and `busy`=1.
  - `msg_ack`=1 for exactly the cycle after that edge.
- **PREAMBLE:**
  - `PREAMBLE_LEN` bits; bit i = ~i[0], giving 1,0,1,0…
- **DATA:**
  - `MSG_LEN` bits, LSB first.
  - CRC is updated once per data bit, at the edge that puts the bit on `tx_data`.
- **CRC:**
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Update rule: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 0).
  - The final CRC is sent in 8 bits, MSB first.
- **EOP:**
  - One bit time with `tx_data`=0 and `tx_en`=1.
- **Frame end:**
  - At the edge ending EOP: state becomes IDLE, `tx_en`=0, `busy`=0, `tx_data`=0, and `tx_done`=1 for one cycle.
- **While busy:** `auth_msg_ready` is ignored and nothing is queued; the driver must hold or re-assert the request.
- **Input stability:** `auth_msg_out` may change freely after the capture edge; only the latched copy is used.

## Timing
- **Reset values:** every output is 0 (`msg_ack`, `busy`, `tx_en`, `tx_data`, `tx_done`). State is IDLE, counters are 0, CRC is 0x00.
- **Reset mid-frame:** `tx_en` and `tx_data` drop to 0 asynchronously. The frame is abandoned and no `tx_done` is produced.
- **First bit:** appears on `tx_data` in the cycle after the capture edge, in the same cycle as `msg_ack`.
- **Bit hold:** each bit is held for exactly `CLK_DIV` cycles. With `CLK_DIV`=1 the bit changes every cycle.
- **Frame length:** (`PREAMBLE_LEN`+`MSG_LEN`+9)×`CLK_DIV` cycles with `tx_en`=1.
- **`tx_done` timing:** `tx_done` is high in the first cycle after `tx_en` falls.
- **Back-to-back frames:** `auth_msg_ready`=1 during the `tx_done` cycle (state is IDLE) is captured. The next frame's `tx_en` then rises one cycle after `tx_done`, giving a minimum one-cycle gap between frames.
- **Counters:**
  - Bit counter is sized to clog2(max(`PREAMBLE_LEN`,`MSG_LEN`)+1).
  - Divider counter is sized to clog2(`CLK_DIV`)+1.
  - Both wrap to 0 at each state transition; there is no off-by-one at the phase boundaries.

## Test plan
All scenarios use `MSG_LEN`=8, `PREAMBLE_LEN`=4, `CLK_DIV`=2.

- **Message 0x01:** pulse ready → `msg_ack` one cycle. `tx_data` per bit time is 1010 | 10000000 | 10001001 (CRC 0x89) | 0. `tx_en` is high for 42 cycles, then `tx_done` pulses once.
- **Message 0x00:** → data 00000000, CRC 0x00 (00000000). Total 42 cycles; `busy` deasserts with `tx_done`.
- **Ready held during frame:** hold `auth_msg_ready`=1 with data 0x01 for the whole frame → no second `msg_ack` until the `tx_done` cycle. The second frame's `tx_en` rises one cycle after `tx_done`.
- **Input changes mid-frame:** change `auth_msg_out` to 0xFF mid-frame with ready=0 → the transmitted data still matches the latched 0x01 and CRC is still 0x89.
- **Reset mid-frame:** assert `reset` during DATA → `tx_en`/`tx_data` go 0 without a clock edge, and no `tx_done` occurs. After release, a new 0x01 request produces a full, correct frame.
- **`CLK_DIV`=1 rerun:** rerun the 0x01 case with `CLK_DIV`=1 → 21 cycles of `tx_en` and an identical bit sequence.
